// File: rtl/msg_block_buffer.sv
// msg_block_buffer: collects up to DEPTH words from a valid/ready stream into
// one packed block and holds it on a valid/ready output until it is taken.
// Word 0 lands in the MSBs. A word flagged with in_last ends a short block;
// the slots that were never written stay zero.
module msg_block_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W*DEPTH-1:0]   out_block,
    output logic [CNT_W-1:0]          out_count,
    output logic [CNT_W-1:0]          fill_count
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [CNT_W-1:0]         r_fill_count;
    logic [CNT_W-1:0]         r_out_count;
    logic [DATA_W*DEPTH-1:0]  w_block;
    logic                     w_flush;
    logic                     w_accept;
    logic                     w_last_word;
    logic                     w_xfer;

    assign w_flush     = !RST || clear;
    assign w_accept    = in_valid && (r_state == S_FILL);
    assign w_last_word = w_accept && (in_last || (r_fill_count == CNT_W'(DEPTH - 1)));
    assign w_xfer      = (r_state == S_FULL) && out_ready;

    // State register: synchronous active-low reset, clear acts like reset
    always_ff @(posedge CLK) begin
        if (w_flush) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: leave FILL on the final word, leave FULL on transfer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FILL: if (w_last_word) w_next_state = S_FULL;
            S_FULL: if (w_xfer)      w_next_state = S_FILL;
            default: w_next_state = S_FILL;
        endcase
    end

    // Handshake outputs decode the state directly
    always_comb begin
        in_ready  = (r_state == S_FILL);
        out_valid = (r_state == S_FULL);
    end

    // Word storage and counters; the block is zeroed on transfer so that a
    // later short block never carries stale words in its unwritten slots
    always_ff @(posedge CLK) begin
        if (w_flush) begin
            r_fill_count <= '0;
            r_out_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (r_fill_count == CNT_W'(i)) begin
                    r_mem[i] <= in_data;
                end
            end
            if (w_last_word) begin
                r_fill_count <= '0;
                r_out_count  <= r_fill_count + CNT_W'(1);
            end else begin
                r_fill_count <= r_fill_count + CNT_W'(1);
            end
        end else if (w_xfer) begin
            r_fill_count <= '0;
            r_out_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end
    end

    // Pack slots into the output vector, slot 0 in the most significant word
    always_comb begin
        w_block = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_block[DATA_W*(DEPTH-i)-1 -: DATA_W] = r_mem[i];
        end
    end

    assign out_block  = w_block;
    assign out_count  = r_out_count;
    assign fill_count = r_fill_count;

endmodule

// File: tb/tb_msg_block_buffer.sv
// Directed bench for msg_block_buffer at the default 16 x 32-bit geometry.
module tb_msg_block_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;
    localparam int TW     = DATA_W * DEPTH;

    logic              CLK = 1'b0;
    logic              RST;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [TW-1:0]     out_block;
    logic [CNT_W-1:0]  out_count;
    logic [CNT_W-1:0]  fill_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [DATA_W-1:0] words [DEPTH];
    logic [TW-1:0]     exp_blk;
    logic [TW-1:0]     held_blk;

    msg_block_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_block  (out_block),
        .out_count  (out_count),
        .fill_count (fill_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 ns later
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Expected block: first n entries of words[], zero in the rest
    function automatic logic [TW-1:0] pack(input int n);
        logic [TW-1:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            r = {r[TW-DATA_W-1:0], (i < n) ? words[i] : {DATA_W{1'b0}}};
        end
        return r;
    endfunction

    int seen;
    int first_cyc;
    int second_cyc;
    int idx;
    logic was_ready;

    initial begin
        RST = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        chk("rst_in_ready",   TW'(in_ready),   TW'(1));
        chk("rst_out_valid",  TW'(out_valid),  TW'(0));
        chk("rst_fill_count", TW'(fill_count), TW'(0));
        chk("rst_out_count",  TW'(out_count),  TW'(0));
        chk("rst_out_block",  out_block,       '0);

        // 1: words 1..16 with out_ready high all along
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) words[k] = DATA_W'(k + 1);
        for (int k = 0; k < DEPTH; k++) begin
            send(words[k], 1'b0);
            if (k == 4)  chk("t1_fill5", TW'(fill_count), TW'(5));
            if (k == 14) chk("t1_not_yet_valid", TW'(out_valid), TW'(0));
        end
        chk("t1_out_valid", TW'(out_valid), TW'(1));
        chk("t1_in_ready",  TW'(in_ready),  TW'(0));
        chk("t1_out_count", TW'(out_count), TW'(16));
        exp_blk = pack(16);
        chk("t1_out_block", out_block, exp_blk);
        tick();
        chk("t1_valid_one_cycle", TW'(out_valid), TW'(0));
        chk("t1_block_cleared",   out_block,      '0);
        chk("t1_count_cleared",   TW'(out_count), TW'(0));

        // 2: stall for 5 cycles while offering a junk word
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) words[k] = DATA_W'(32'h100 + k);
        for (int k = 0; k < DEPTH; k++) send(words[k], 1'b0);
        held_blk = pack(16);
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t2_hold_valid", TW'(out_valid), TW'(1));
            chk("t2_hold_ready", TW'(in_ready),  TW'(0));
            chk("t2_hold_block", out_block,      held_blk);
        end
        in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1;
        tick();
        chk("t2_released", TW'(out_valid), TW'(0));

        // 1-word block right after the stall: no 0xDEADBEEF anywhere
        words[0] = 32'h0000_0099;
        send(words[0], 1'b1);
        chk("t2_one_word_count", TW'(out_count), TW'(1));
        exp_blk = pack(1);
        chk("t2_one_word_block", out_block, exp_blk);
        tick();

        // 3: in_last on the third word
        words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
        send(words[0], 1'b0);
        send(words[1], 1'b0);
        send(words[2], 1'b1);
        chk("t3_out_valid", TW'(out_valid), TW'(1));
        chk("t3_out_count", TW'(out_count), TW'(3));
        exp_blk = pack(3);
        chk("t3_out_block", out_block, exp_blk);
        tick();

        // in_last on word DEPTH-1 behaves as a normal full block
        for (int k = 0; k < DEPTH; k++) words[k] = DATA_W'(32'h5000 + k);
        for (int k = 0; k < DEPTH; k++) send(words[k], k == DEPTH - 1);
        chk("t3b_out_count", TW'(out_count), TW'(16));
        exp_blk = pack(16);
        chk("t3b_out_block", out_block, exp_blk);
        tick();

        // 4: reset after 7 accepted words, with a word on the input at that edge
        for (int k = 0; k < 7; k++) send(32'hBAD0_0000 + k, 1'b0);
        chk("t4_fill7", TW'(fill_count), TW'(7));
        RST = 1'b0; in_valid = 1'b1; in_data = 32'hBAD0_FFFF;
        tick();
        RST = 1'b1; in_valid = 1'b0; in_data = '0;
        chk("t4_fill_count", TW'(fill_count), TW'(0));
        chk("t4_out_valid",  TW'(out_valid),  TW'(0));
        chk("t4_in_ready",   TW'(in_ready),   TW'(1));
        for (int k = 0; k < DEPTH; k++) words[k] = DATA_W'(32'h7700 + k);
        for (int k = 0; k < DEPTH; k++) send(words[k], 1'b0);
        exp_blk = pack(16);
        chk("t4_block_fresh", out_block, exp_blk);
        tick();

        // 5: clear with a word offered at fill_count 4
        for (int k = 0; k < 4; k++) send(32'hC0 + k, 1'b0);
        chk("t5_fill4", TW'(fill_count), TW'(4));
        clear = 1'b1; in_valid = 1'b1; in_data = 32'h55;
        tick();
        clear = 1'b0; in_valid = 1'b0; in_data = '0;
        chk("t5_fill_count", TW'(fill_count), TW'(0));
        chk("t5_out_valid",  TW'(out_valid),  TW'(0));
        words[0] = 32'h77;
        send(words[0], 1'b1);
        exp_blk = pack(1);
        chk("t5_block_after_clear", out_block, exp_blk);
        tick();

        // 6: two back-to-back blocks, in_valid and out_ready always high
        for (int k = 0; k < DEPTH; k++) words[k] = DATA_W'(32'h1111_0000 + k);
        seen = 0; first_cyc = -1; second_cyc = -1; idx = 0;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && seen < 2; cyc++) begin
            was_ready = in_ready;
            if (was_ready) in_data = words[idx % DEPTH] ^ ((idx >= DEPTH) ? 32'hFFFF_0000 : 32'h0);
            else           in_data = 32'hDEADBEEF;
            tick();
            if (was_ready) idx++;
            if (out_valid) begin
                if (seen == 0) begin
                    first_cyc = cyc;
                    exp_blk = pack(16);
                    chk("t6_block_a", out_block, exp_blk);
                end else begin
                    second_cyc = cyc;
                    for (int k = 0; k < DEPTH; k++) words[k] = words[k] ^ 32'hFFFF_0000;
                    exp_blk = pack(16);
                    chk("t6_block_b", out_block, exp_blk);
                end
                seen++;
            end
        end
        in_valid = 1'b0; in_data = '0;
        chk("t6_blocks_seen", TW'(seen), TW'(2));
        chk("t6_period", TW'(second_cyc - first_cyc), TW'(17));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
